// File: rtl/chdr_pkg.sv
// Shared CHDR definitions: header bit fields, type codes, deframer states
// and the tuser layout that the sample framer also uses.
package chdr_pkg;

  localparam int unsigned CHDR_W  = 64;
  localparam int unsigned TUSER_W = 128;
  localparam int unsigned SEQ_W   = 12;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned SID_W   = 32;
  localparam int unsigned TS_W    = 64;
  localparam int unsigned HI_W    = 16;

  // Header bit positions
  localparam int unsigned HDR_TYPE_MSB = 63;
  localparam int unsigned HDR_TYPE_LSB = 62;
  localparam int unsigned HDR_HAS_TIME = 61;
  localparam int unsigned HDR_EOB      = 60;
  localparam int unsigned HDR_SEQ_MSB  = 59;
  localparam int unsigned HDR_SEQ_LSB  = 48;
  localparam int unsigned HDR_LEN_MSB  = 47;
  localparam int unsigned HDR_LEN_LSB  = 32;
  localparam int unsigned HDR_SID_MSB  = 31;
  localparam int unsigned HDR_SID_LSB  = 0;

  // Header overhead in bytes, without and with a timestamp word
  localparam logic [LEN_W-1:0] HDR_BYTES      = LEN_W'(8);
  localparam logic [LEN_W-1:0] HDR_TIME_BYTES = LEN_W'(16);

  typedef enum logic [1:0] {
    CHDR_TYPE_DATA = 2'b00,
    CHDR_TYPE_CMD  = 2'b01,
    CHDR_TYPE_RESP = 2'b11
  } chdr_type_t;

  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,
    ST_TIME = 2'd1,
    ST_BODY = 2'd2,
    ST_DROP = 2'd3
  } deframer_state_t;

  // tuser = {hdr[63:48], payload_len, sid, timestamp}
  typedef struct packed {
    logic [HI_W-1:0]  hdr_hi;
    logic [LEN_W-1:0] payload_len;
    logic [SID_W-1:0] sid;
    logic [TS_W-1:0]  timestamp;
  } chdr_tuser_t;

  // Command and response packets carry no samples
  function automatic logic chdr_is_ctrl(input logic [1:0] pkt_type);
    return (pkt_type == CHDR_TYPE_CMD) || (pkt_type == CHDR_TYPE_RESP);
  endfunction

  // Payload bytes after the header (and timestamp), 16-bit wrap
  function automatic logic [LEN_W-1:0] chdr_payload_len(input logic [CHDR_W-1:0] hdr);
    logic [LEN_W-1:0] ovh;
    ovh = hdr[HDR_HAS_TIME] ? HDR_TIME_BYTES : HDR_BYTES;
    return LEN_W'(hdr[HDR_LEN_MSB:HDR_LEN_LSB] - ovh);
  endfunction

  function automatic chdr_tuser_t chdr_tuser_pack(input logic [CHDR_W-1:0] hdr,
                                                  input logic [LEN_W-1:0]  plen,
                                                  input logic [TS_W-1:0]   ts);
    chdr_tuser_t t;
    t.hdr_hi      = hdr[HDR_TYPE_MSB:HDR_SEQ_LSB];
    t.payload_len = plen;
    t.sid         = hdr[HDR_SID_MSB:HDR_SID_LSB];
    t.timestamp   = ts;
    return t;
  endfunction

endpackage

// File: rtl/chdr_deframer_gearbox.sv
// 64-to-32 split of CHDR body words: upper half first, lower half second.
// The input word is held while the upper half is shown and consumed with the
// lower half, or with the upper half alone when the payload ends mid-word.
module chdr_deframer_gearbox
  import chdr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              i_en,
  input  logic [CHDR_W-1:0] i_tdata,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  input  logic              i_trim,
  output logic              o_in_tready,
  output logic [31:0]       o_tdata,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              i_out_tready
);

  logic r_half;
  logic w_trim_beat;
  logic w_beat;

  // Last word with a half-word payload: emit only the upper half
  assign w_trim_beat  = ~r_half & i_tlast & i_trim;
  assign o_tdata      = r_half ? i_tdata[31:0] : i_tdata[63:32];
  assign o_tlast      = i_tlast & (r_half | i_trim);
  assign o_tvalid     = i_en & i_tvalid;
  assign o_in_tready  = i_en & i_out_tready & (r_half | w_trim_beat);
  assign w_beat       = o_tvalid & i_out_tready;

  // Half selector advances on every output beat except a trimmed last one
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_half <= 1'b0;
    end else if (w_beat && !w_trim_beat) begin
      r_half <= ~r_half;
    end
  end

endmodule

// File: rtl/chdr_deframer_64to32.sv
// CHDR deframer: strips header/timestamp from 64-bit CHDR packets, presents
// them as a 128-bit tuser and streams the payload as WIDTH-bit samples.
// Control (command/response) packets and header-only packets are discarded.
// Optional sequence-number checking: define CHDR_DEFRAMER_SEQ_CHECK_EN.
module chdr_deframer_64to32
  import chdr_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [CHDR_W-1:0]  i_tdata,
  input  logic               i_tlast,
  input  logic               i_tvalid,
  output logic               i_tready,
  output logic [WIDTH-1:0]   o_tdata,
  output logic [TUSER_W-1:0] o_tuser,
  output logic               o_tlast,
  output logic               o_tvalid,
  input  logic               o_tready
`ifdef CHDR_DEFRAMER_SEQ_CHECK_EN
  ,
  output logic               seq_err,
  output logic [15:0]        seq_err_cnt
`endif
);

  if (!(WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
    $error("chdr_deframer_64to32: WIDTH must be 32 or 64");
  end

  deframer_state_t  r_state;
  chdr_tuser_t      r_tuser;

  logic [1:0]       w_type;
  logic             w_has_time;
  logic             w_is_ctrl;
  logic [LEN_W-1:0] w_plen;
  logic             w_in_body;
  logic             w_in_hs;

  logic [WIDTH-1:0] w_body_tdata;
  logic             w_body_tvalid;
  logic             w_body_tlast;
  logic             w_body_tready;

  assign w_type     = i_tdata[HDR_TYPE_MSB:HDR_TYPE_LSB];
  assign w_has_time = i_tdata[HDR_HAS_TIME];
  assign w_is_ctrl  = chdr_is_ctrl(w_type);
  assign w_plen     = chdr_payload_len(i_tdata);
  assign w_in_body  = (r_state == ST_BODY);
  assign w_in_hs    = i_tvalid & i_tready;
  assign o_tuser    = r_tuser;

  // Body path: straight passthrough at 64 bits, gearbox split at 32 bits
  if (WIDTH == 64) begin : g_w64
    assign w_body_tdata  = i_tdata;
    assign w_body_tvalid = i_tvalid;
    assign w_body_tlast  = i_tlast;
    assign w_body_tready = o_tready;
  end else begin : g_w32
    chdr_deframer_gearbox u_gearbox (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .i_en         (w_in_body),
      .i_tdata      (i_tdata),
      .i_tlast      (i_tlast),
      .i_tvalid     (i_tvalid),
      .i_trim       (r_tuser.payload_len[2]),
      .o_in_tready  (w_body_tready),
      .o_tdata      (w_body_tdata),
      .o_tlast      (w_body_tlast),
      .o_tvalid     (w_body_tvalid),
      .i_out_tready (o_tready)
    );
  end

  // Handshake steering: header/time/drop always accept, body follows output
  always_comb begin
    i_tready = 1'b0;
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    o_tdata  = w_body_tdata;
    case (r_state)
      ST_BODY: begin
        i_tready = w_body_tready;
        o_tvalid = w_body_tvalid;
        o_tlast  = w_body_tlast;
      end
      default: begin
        i_tready = 1'b1;
      end
    endcase
  end

  // Packet parser; tuser only changes outside the body, while no sample is shown
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state <= ST_HEAD;
      r_tuser <= '0;
    end else begin
      case (r_state)
        ST_HEAD: begin
          if (i_tvalid) begin
            if (!w_is_ctrl) begin
              r_tuser <= chdr_tuser_pack(i_tdata, w_plen, TS_W'(0));
            end
            if (i_tlast) begin
              r_state <= ST_HEAD;
            end else if (w_is_ctrl) begin
              r_state <= ST_DROP;
            end else if (w_has_time) begin
              r_state <= ST_TIME;
            end else begin
              r_state <= ST_BODY;
            end
          end
        end
        ST_TIME: begin
          if (i_tvalid) begin
            r_tuser.timestamp <= i_tdata;
            r_state           <= i_tlast ? ST_HEAD : ST_BODY;
          end
        end
        ST_BODY: begin
          if (w_in_hs && i_tlast) begin
            r_state <= ST_HEAD;
          end
        end
        ST_DROP: begin
          if (i_tvalid && i_tlast) begin
            r_state <= ST_HEAD;
          end
        end
        default: begin
          r_state <= ST_HEAD;
        end
      endcase
    end
  end

`ifdef CHDR_DEFRAMER_SEQ_CHECK_EN
  logic [SEQ_W-1:0] r_exp_seq;
  logic             r_seq_valid;
  logic             r_seq_err;
  logic [15:0]      r_seq_err_cnt;
  logic [SEQ_W-1:0] w_seqnum;
  logic             w_data_hdr_hs;

  assign w_seqnum      = i_tdata[HDR_SEQ_MSB:HDR_SEQ_LSB];
  assign w_data_hdr_hs = (r_state == ST_HEAD) & i_tvalid & ~i_tlast & ~w_is_ctrl;
  assign seq_err       = r_seq_err;
  assign seq_err_cnt   = r_seq_err_cnt;

  // Sequence tracker: flag a gap once, then resync to the received number
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_exp_seq     <= '0;
      r_seq_valid   <= 1'b0;
      r_seq_err     <= 1'b0;
      r_seq_err_cnt <= '0;
    end else begin
      r_seq_err <= 1'b0;
      if (w_data_hdr_hs) begin
        r_exp_seq   <= SEQ_W'(w_seqnum + SEQ_W'(1));
        r_seq_valid <= 1'b1;
        if (r_seq_valid && (w_seqnum != r_exp_seq)) begin
          r_seq_err <= 1'b1;
          if (r_seq_err_cnt != 16'hFFFF) begin
            r_seq_err_cnt <= r_seq_err_cnt + 16'd1;
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_chdr_deframer_64to32.sv
// Directed bench for chdr_deframer_64to32: a WIDTH=32 and a WIDTH=64 instance,
// each driven by its own packet driver; output beats are captured and compared
// against hand-computed sample/tuser values.
module tb_chdr_deframer_64to32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, clear;

  // Instance 0: WIDTH=32
  logic [63:0]  in_d0;
  logic         in_l0, in_v0, in_r0, out_r0;
  logic [31:0]  out_d0;
  logic [127:0] out_u0;
  logic         out_l0, out_v0;
  // Instance 1: WIDTH=64
  logic [63:0]  in_d1;
  logic         in_l1, in_v1, in_r1, out_r1;
  logic [63:0]  out_d1;
  logic [127:0] out_u1;
  logic         out_l1, out_v1;

`ifdef CHDR_DEFRAMER_SEQ_CHECK_EN
  logic        seq_err0, seq_err1;
  logic [15:0] seq_cnt0, seq_cnt1;
`endif

  chdr_deframer_64to32 #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(in_d0), .i_tlast(in_l0), .i_tvalid(in_v0), .i_tready(in_r0),
    .o_tdata(out_d0), .o_tuser(out_u0), .o_tlast(out_l0), .o_tvalid(out_v0),
    .o_tready(out_r0)
`ifdef CHDR_DEFRAMER_SEQ_CHECK_EN
    , .seq_err(seq_err0), .seq_err_cnt(seq_cnt0)
`endif
  );

  chdr_deframer_64to32 #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(in_d1), .i_tlast(in_l1), .i_tvalid(in_v1), .i_tready(in_r1),
    .o_tdata(out_d1), .o_tuser(out_u1), .o_tlast(out_l1), .o_tvalid(out_v1),
    .o_tready(out_r1)
`ifdef CHDR_DEFRAMER_SEQ_CHECK_EN
    , .seq_err(seq_err1), .seq_err_cnt(seq_cnt1)
`endif
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Captured output beats per instance
  logic [63:0]  cap_d0[$], cap_d1[$];
  logic         cap_l0[$], cap_l1[$];
  logic [127:0] cap_u0[$], cap_u1[$];
  int           n_pulse = 0;

  always @(negedge clk) begin
    if (out_v0 && out_r0) begin
      cap_d0.push_back({32'd0, out_d0});
      cap_l0.push_back(out_l0);
      cap_u0.push_back(out_u0);
    end
    if (out_v1 && out_r1) begin
      cap_d1.push_back(out_d1);
      cap_l1.push_back(out_l1);
      cap_u1.push_back(out_u1);
    end
`ifdef CHDR_DEFRAMER_SEQ_CHECK_EN
    if (seq_err0) n_pulse++;
`endif
  end

  logic [63:0] pkt[$];
  logic [63:0] exp_d[$];
  logic [127:0] exp_u;

  function automatic logic [63:0] mk_hdr(input logic [1:0] t, input logic ht,
                                         input logic [11:0] seq, input logic [15:0] len,
                                         input logic [31:0] sid);
    return {t, ht, 1'b0, seq, len, sid};
  endfunction

  task automatic set_in(input int sel, input logic [63:0] d, input logic l, input logic v);
    if (sel == 0) begin in_d0 = d; in_l0 = l; in_v0 = v; end
    else          begin in_d1 = d; in_l1 = l; in_v1 = v; end
  endtask

  // Drive every word of pkt, tlast on the final one, bounded wait per word
  task automatic drive_pkt(input int sel);
    bit ok;
    for (int i = 0; i < pkt.size(); i++) begin
      set_in(sel, pkt[i], (i == pkt.size() - 1), 1'b1);
      ok = 1'b0;
      for (int n = 0; n < 400 && !ok; n++) begin
        @(negedge clk);
        ok = (sel == 0) ? in_r0 : in_r1;
        @(posedge clk);
        #1;
      end
      if (!ok) check_val($sformatf("hs_timeout_s%0d_w%0d", sel, i), 128'd0, 128'd1);
    end
    set_in(sel, 64'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_caps();
    cap_d0.delete(); cap_l0.delete(); cap_u0.delete();
    cap_d1.delete(); cap_l1.delete(); cap_u1.delete();
  endtask

  // Compare captured beats with exp_d / exp_u; tlast expected on final beat only
  task automatic expect_beats(input string name, input int sel);
    logic [63:0]  gd[$];
    logic         gl[$];
    logic [127:0] gu[$];
    if (sel == 0) begin gd = cap_d0; gl = cap_l0; gu = cap_u0; end
    else          begin gd = cap_d1; gl = cap_l1; gu = cap_u1; end
    check_val({name, "_count"}, 128'(gd.size()), 128'(exp_d.size()));
    for (int i = 0; i < gd.size() && i < exp_d.size(); i++) begin
      check_val($sformatf("%s_data%0d", name, i), 128'(gd[i]), 128'(exp_d[i]));
      check_val($sformatf("%s_last%0d", name, i), 128'(gl[i]), 128'(i == exp_d.size() - 1));
      check_val($sformatf("%s_user%0d", name, i), gu[i], exp_u);
    end
    clear_caps();
  endtask

  initial begin
    bit tog_done;
    reset = 1'b1; clear = 1'b0;
    set_in(0, 64'd0, 1'b0, 1'b0);
    set_in(1, 64'd0, 1'b0, 1'b0);
    out_r0 = 1'b1; out_r1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("rst_valid32", 128'(out_v0), 128'd0);
    check_val("rst_last32",  128'(out_l0), 128'd0);
    check_val("rst_user32",  out_u0,       128'd0);
    check_val("rst_ready32", 128'(in_r0),  128'd1);
    check_val("rst_valid64", 128'(out_v1), 128'd0);
    check_val("rst_user64",  out_u1,       128'd0);
    check_val("rst_ready64", 128'(in_r1),  128'd1);
    @(posedge clk); #1;

    // W64: len 24, no time, two body words, zero-latency passthrough
    clear_caps();
    pkt   = '{mk_hdr(2'b00, 1'b0, 12'd0, 16'd24, 32'h0000ABCD),
              64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    exp_d = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    exp_u = 128'h0000_0010_0000ABCD_0000000000000000;
    drive_pkt(1);
    expect_beats("w64_basic", 1);

    // W32: has_time, len 36 -> payload 20 bytes, last word trimmed to hi
    pkt   = '{mk_hdr(2'b00, 1'b1, 12'd1, 16'd36, 32'h00000002), 64'h1234,
              {32'd1, 32'd2}, {32'd3, 32'd4}};
    exp_d = '{64'd1, 64'd2, 64'd3};
    exp_u = 128'h2001_0014_00000002_0000000000001234;
    drive_pkt(0);
    expect_beats("w32_trim", 0);

    // W32: len 12 with time -> payload wraps to 0xFFFC, single hi sample
    pkt   = '{mk_hdr(2'b00, 1'b1, 12'd2, 16'd12, 32'h00000003), 64'h55, {32'd7, 32'd8}};
    exp_d = '{64'd7};
    exp_u = 128'h2002_FFFC_00000003_0000000000000055;
    drive_pkt(0);
    expect_beats("w32_wrap", 0);

    // Header-only packet produces nothing; the following one is intact
    pkt   = '{mk_hdr(2'b00, 1'b0, 12'd3, 16'd8, 32'h00000004)};
    exp_d = {};
    drive_pkt(0);
    expect_beats("hdr_only", 0);
    pkt   = '{mk_hdr(2'b00, 1'b0, 12'd3, 16'd16, 32'h00000004), {32'd5, 32'd6}};
    exp_d = '{64'd5, 64'd6};
    exp_u = 128'h0003_0008_00000004_0000000000000000;
    drive_pkt(0);
    expect_beats("after_hdr_only", 0);

    // Command packet on W64 and response packet on W32 are swallowed
    pkt   = '{mk_hdr(2'b01, 1'b0, 12'd0, 16'd40, 32'h00000009),
              64'hA1, 64'hA2, 64'hA3, 64'hA4};
    exp_d = {};
    drive_pkt(1);
    expect_beats("cmd_drop64", 1);
    pkt   = '{mk_hdr(2'b11, 1'b0, 12'd0, 16'd24, 32'h00000001), 64'hB1, 64'hB2};
    drive_pkt(0);
    expect_beats("resp_drop32", 0);
    pkt   = '{mk_hdr(2'b00, 1'b0, 12'd5, 16'd16, 32'h00000005), 64'hDEAD_BEEF_0BAD_F00D};
    exp_d = '{64'hDEAD_BEEF_0BAD_F00D};
    exp_u = 128'h0005_0008_00000005_0000000000000000;
    drive_pkt(1);
    expect_beats("after_cmd64", 1);

    // W32 type 2'b10 data, 8 words, output ready toggling every cycle
    pkt = '{mk_hdr(2'b10, 1'b0, 12'd6, 16'd72, 32'h00000006)};
    exp_d = {};
    for (int i = 0; i < 8; i++) begin
      pkt.push_back({32'(2 * i), 32'(2 * i + 1)});
      exp_d.push_back(64'(2 * i));
      exp_d.push_back(64'(2 * i + 1));
    end
    exp_u = 128'h8006_0040_00000006_0000000000000000;
    tog_done = 1'b0;
    fork
      begin drive_pkt(0); tog_done = 1'b1; end
      begin
        while (!tog_done) begin
          @(posedge clk); #1;
          out_r0 = ~out_r0;
        end
      end
    join
    out_r0 = 1'b1;
    expect_beats("w32_toggle", 0);

    // W64 never trims: len 36 with time emits both words
    pkt   = '{mk_hdr(2'b00, 1'b1, 12'd7, 16'd36, 32'h00000007), 64'h99,
              64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718};
    exp_d = '{64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718};
    exp_u = 128'h2007_0014_00000007_0000000000000099;
    drive_pkt(1);
    expect_beats("w64_notrim", 1);

`ifdef CHDR_DEFRAMER_SEQ_CHECK_EN
    // Sequence tracker: 0,1,3,4 -> one error on 3
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(posedge clk); #1;
    n_pulse = 0;
    check_val("seq_cnt_clear", 128'(seq_cnt0), 128'd0);
    begin
      logic [11:0] seqs[4];
      int          exp_pulse[4];
      seqs = '{12'd0, 12'd1, 12'd3, 12'd4};
      exp_pulse = '{0, 0, 1, 1};
      for (int k = 0; k < 4; k++) begin
        pkt = '{mk_hdr(2'b00, 1'b0, seqs[k], 16'd16, 32'h00000008), 64'h42};
        drive_pkt(0);
        check_val($sformatf("seq_pulses_p%0d", k), 128'(n_pulse), 128'(exp_pulse[k]));
      end
    end
    check_val("seq_err_cnt", 128'(seq_cnt0), 128'd1);
    clear_caps();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/chdr_deframer_64to32.md
Name: chdr_deframer_64to32

Overview:
- Receive-side counterpart of the sample-to-CHDR framer: consumes 64-bit CHDR packets on one clock domain and emits a WIDTH-bit sample stream.
- Each sample packet is accompanied by a 128-bit tuser carrying the CHDR header, the timestamp and the payload length.
- Sits between the crossbar/NoC shell output and sample-domain user logic.
- Reproduces the framer's tuser format exactly, so framer→deframer round trips are lossless.

Parameters:
- WIDTH, 32, output sample width. Only 32 or 64 are legal; elaborate-time error otherwise.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush; same effect as reset on state; takes effect the cycle after assertion
- i_tdata  in  64  CHDR word
- i_tlast  in  1  last CHDR word of packet
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  WIDTH  sample data
- o_tuser  out  128  {hdr[63:48], payload_len[15:0], hdr[31:0], timestamp[63:0]}; stable for the whole output packet
- o_tlast  out  1  last sample of packet
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready

Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.

Behaviour:
- CHDR header fields:
  - [63:62] type
  - [61] has_time
  - [60] eob
  - [59:48] seqnum
  - [47:32] length in bytes, header included
  - [31:0] sid
- payload_len = length − (has_time ? 16 : 8), 16-bit wrap arithmetic.
- States: ST_HEAD, ST_TIME, ST_BODY, ST_DROP. Reset/clear → ST_HEAD, o_tvalid=0, o_tlast=0, o_tuser=0.
- ST_HEAD:
  - i_tready=1, o_tvalid=0.
  - On a handshake, latch the header into tuser regs with payload_len substituted.
  - Latch timestamp=0 if has_time=0.
  - Next state:
    - If i_tlast → ST_HEAD; header-only packet, dropped, no output.
    - Else if has_time → ST_TIME.
    - Else → ST_BODY.
- ST_TIME:
  - i_tready=1.
  - On a handshake, latch timestamp.
  - Next state: i_tlast → ST_HEAD (dropped); else → ST_BODY.
- ST_BODY, WIDTH=64:
  - o_tdata=i_tdata, o_tvalid=i_tvalid, i_tready=o_tready, o_tlast=i_tlast. Zero latency.
  - On i_tlast handshake → ST_HEAD.
- ST_BODY, WIDTH=32:
  - Each 64-bit word is emitted as hi [63:32] first, then lo [31:0].
  - Internal half flag: i_tready=o_tready only while emitting lo; hi is shown without consuming the input word.
  - Trim: on the i_tlast word, if payload_len[2]=1, emit hi only with o_tlast=1 and consume the word on that beat.
  - Otherwise o_tlast is asserted on lo.
- i_tlast always ends the packet, even if it disagrees with the length field. The length field is used only for the trim decision.
- o_tuser must not change while in ST_BODY. Header regs update only in ST_HEAD/ST_TIME, when o_tvalid=0.
- ST_DROP: entered when type==2'b01 (command) or type==2'b11 (response). Consumes words with i_tready=1 until the i_tlast handshake → ST_HEAD.
- o_tvalid must never deassert without a handshake while in ST_BODY, provided i_tvalid holds (AXIS rule passthrough).
- Reset or clear mid-packet: the remainder of the in-flight input packet is treated as a new header. Upstream guarantees clear is issued only at packet boundaries.

Optional Feature:
- Macro: CHDR_DEFRAMER_SEQ_CHECK_EN.
- With the macro:
  - Adds output seq_err (1-bit pulse) and seq_err_cnt (16-bit saturating).
  - Tracks expected seqnum per accepted data packet (12-bit wrap, 4095→0).
  - On a mismatch: pulse seq_err for one cycle in the cycle after the header handshake, then resync expected to the received seqnum+1.
  - The first packet after reset/clear sets the expectation and never flags.
  - Dropped packets do not advance the tracker.
- Without the macro: no extra ports, no tracking logic.

Decomposition:
- Shared package chdr_pkg holds:
  - header bit-field position constants
  - CHDR type codes
  - state encodings
  - the tuser packing layout, shared with the framer
- One natural sub-module: chdr_deframer_gearbox, the 64→32 split with trim. It is instantiated only when WIDTH=32 and bypassed for WIDTH=64.

Test Plan:
- WIDTH=64, header len=24, no time, 2 body words A,B:
  - o_tdata=A then B; o_tlast on B.
  - o_tuser[111:96]=16; o_tuser[63:0]=0.
- WIDTH=32, has_time, len=36, timestamp=0x1234, body words {1,2},{3,4}, i_tlast on second:
  - Outputs 1,2,3 with o_tlast on 3; value 4 is trimmed.
  - payload_len=20; o_tuser[63:0]=0x1234.
- Header-only packet (len=8, i_tlast on header) followed by a normal packet: no output for the first; the second is correct.
- Command-type packet of 5 words: all consumed, zero output beats. The next data packet passes.
- WIDTH=32, o_tready toggling 1/0 every cycle across an 8-word packet: all 16 samples in order; o_tuser stable throughout; no duplicates or losses.
- SEQ_CHECK_EN, seqnums 0,1,3,4:
  - One seq_err pulse after seqnum 3's header; seq_err_cnt=1.
  - seqnum 4 does not flag.
